dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_seq_pkg.sv | 26 ++
 rtl/dsp_seq_tokpipe.sv | 26 ++
 rtl/dsp_mac_seq.sv | 145 ++++++++++++++
 tb/tb_dsp_mac_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg -- shared types and constants for the DSP MAC sequencer.
//   state_t            : sequencer state encoding
//   OPMODE_IDLE        : DSP OPMODE while no accumulation is running
//   OPMODE_MAC         : DSP OPMODE for accumulate (X=M, Z=P)
//   OPMODE_PREADD_BIT  : OPMODE bit that enables the DSP pre-adder
// Build option: DSP_SEQ_PREADD_EN sets the pre-adder bit in OPMODE_MAC.
package dsp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int         OPMODE_PREADD_BIT = 4;
    localparam logic [7:0] OPMODE_IDLE       = 8'h00;

`ifdef DSP_SEQ_PREADD_EN
    localparam logic [7:0] OPMODE_MAC = 8'b0000_1001 | (8'd1 << OPMODE_PREADD_BIT);
`else
    localparam logic [7:0] OPMODE_MAC = 8'b0000_1001;
`endif

endpackage

// File: rtl/dsp_seq_tokpipe.sv
// dsp_seq_tokpipe -- 2-stage token shift register tracking beats in flight
// through the DSP M and P registers.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous clear of both stages
//   launch : token entering stage 0 on the next edge
//   tok    : tok[0] = beat entering M, tok[1] = beat entering P
module dsp_seq_tokpipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       launch,
    output logic [1:0] tok
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok <= 2'b00;
        end else if (flush) begin
            tok <= 2'b00;
        end else begin
            tok <= {tok[0], launch};
        end
    end

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq -- sequences a DSP slice (A/B -> M -> P) through one
// multiply-accumulate job of len beats.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, len      : job request and beat count (sampled in IDLE)
//   abort           : synchronous job cancel
//   in_valid        : operand pair present; in_ready : beat accepted
//   ce_ab/ce_m/ce_p : DSP register clock enables
//   rst_p           : synchronous clear of the DSP P register
//   opmode          : DSP OPMODE
//   busy, done      : job in progress / one-cycle completion pulse
//   ce_d            : D register enable, only with DSP_SEQ_PREADD_EN
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start
// ST_CLR    | one cycle clearing P, counter already loaded
// ST_STREAM | accepting beats until the counter expires
// ST_DRAIN  | waiting for the last beats to reach P
// ST_DONE   | one-cycle done pulse, P holds the final sum
module dsp_mac_seq
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int OPMODE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                ce_ab,
    output logic                ce_m,
    output logic                ce_p,
    output logic                rst_p,
    output logic [OPMODE_W-1:0] opmode,
`ifdef DSP_SEQ_PREADD_EN
    output logic                ce_d,
`endif
    output logic                busy,
    output logic                done
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [1:0]       tok;
    logic [7:0]       opmode_sel;
    logic             abort_eff;
    logic             accept;
    logic             load;

    // abort only acts on a running job
    assign abort_eff = abort && (state != ST_IDLE);
    assign load      = (state == ST_IDLE) && start && (len != '0);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        rst_p      = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        opmode_sel = OPMODE_IDLE;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_CLR : ST_DONE;
                end
            end
            ST_CLR: begin
                rst_p     = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                in_ready   = 1'b1;
                opmode_sel = OPMODE_MAC;
                if (in_valid && (cnt == LEN_W'(1))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                opmode_sel = OPMODE_MAC;
                // no beats enter in DRAIN, so once stage 0 is empty the last
                // token is leaving stage 1 and P is final after this edge
                if (!tok[0]) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // abort overrides everything, including a final accept
        if (abort_eff) begin
            state_nxt = ST_IDLE;
            rst_p     = 1'b1;
            in_ready  = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (abort_eff) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (accept) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    dsp_seq_tokpipe u_tokpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (abort_eff),
        .launch (accept),
        .tok    (tok)
    );

    assign ce_ab  = accept;
    // P is being cleared on an abort cycle, so in-flight beats are dropped
    assign ce_m   = tok[0] && !abort_eff;
    assign ce_p   = tok[1] && !abort_eff;
    assign opmode = OPMODE_W'(opmode_sel);

`ifdef DSP_SEQ_PREADD_EN
    assign ce_d = accept;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
module tb_dsp_mac_seq;

    localparam int LEN_W    = 8;
    localparam int OPMODE_W = 8;
`ifdef DSP_SEQ_PREADD_EN
    localparam logic [7:0] OP_MAC = 8'h19;
`else
    localparam logic [7:0] OP_MAC = 8'h09;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic                abort;
    logic                in_valid;
    logic                in_ready;
    logic                ce_ab;
    logic                ce_m;
    logic                ce_p;
    logic                rst_p;
    logic [OPMODE_W-1:0] opmode;
    logic                busy;
    logic                done;
`ifdef DSP_SEQ_PREADD_EN
    logic                ce_d;
    wire  [15:0]         outs = {ce_d, in_ready, ce_ab, ce_m, ce_p, rst_p, busy, done, opmode};
`else
    wire  [14:0]         outs = {in_ready, ce_ab, ce_m, ce_p, rst_p, busy, done, opmode};
`endif

    dsp_mac_seq #(.LEN_W(LEN_W), .OPMODE_W(OPMODE_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ce_ab    (ce_ab),
        .ce_m     (ce_m),
        .ce_p     (ce_p),
        .rst_p    (rst_p),
        .opmode   (opmode),
`ifdef DSP_SEQ_PREADD_EN
        .ce_d     (ce_d),
`endif
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // per-cycle records of the last captured run (cycle 0 = start cycle)
    logic [31:0] r_rst_p, r_ce_ab, r_ce_m, r_ce_p, r_done, r_busy, r_rdy, r_mac;
    int          c_ce_ab, c_ce_p, c_done, done_cyc;
    logic [7:0]  op_c0, op_c3;

    // Drives one run cycle by cycle and records outputs at the falling edge.
    // Entered and left at 1 time unit after a rising edge.
    task automatic capture(input int n, input logic [31:0] st_v, input logic [LEN_W-1:0] l,
                           input logic [31:0] iv_v, input logic [31:0] ab_v, input bit iv_hold);
        r_rst_p = '0; r_ce_ab = '0; r_ce_m = '0; r_ce_p = '0;
        r_done = '0; r_busy = '0; r_rdy = '0; r_mac = '0;
        c_ce_ab = 0; c_ce_p = 0; c_done = 0; done_cyc = -1;
        op_c0 = 8'hxx; op_c3 = 8'hxx;
        len = l;
        for (int c = 0; c < n; c++) begin
            start    = (c < 32) ? st_v[c] : 1'b0;
            abort    = (c < 32) ? ab_v[c] : 1'b0;
            in_valid = (c < 32) ? iv_v[c] : iv_hold;
            @(negedge clk);
            if (c < 32) begin
                r_rst_p[c] = rst_p;
                r_ce_ab[c] = ce_ab;
                r_ce_m[c]  = ce_m;
                r_ce_p[c]  = ce_p;
                r_done[c]  = done;
                r_busy[c]  = busy;
                r_rdy[c]   = in_ready;
                r_mac[c]   = (opmode == OPMODE_W'(OP_MAC));
            end
            if (c == 0) op_c0 = opmode;
            if (c == 3) op_c3 = opmode;
            c_ce_ab += int'(ce_ab);
            c_ce_p  += int'(ce_p);
            c_done  += int'(done);
            if (done) done_cyc = c;
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; len = '0;
        #3;
        n_cmp++;
        if (outs !== '0) begin
            n_bad++; $display("FAIL reset_outs: got %h want 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== '0) begin
            n_bad++; $display("FAIL idle_outs: got %h want 0", outs);
        end
    endtask

    task automatic test_basic();
        capture(12, 32'h1, 8'd4, 32'hFFFF_FFFF, 32'h0, 1'b0);
        n_cmp++; if (r_rst_p !== 32'h002) begin n_bad++; $display("FAIL basic_rst_p: got %h want 002", r_rst_p); end
        n_cmp++; if (r_ce_ab !== 32'h03C) begin n_bad++; $display("FAIL basic_ce_ab: got %h want 03c", r_ce_ab); end
        n_cmp++; if (r_ce_m  !== 32'h078) begin n_bad++; $display("FAIL basic_ce_m: got %h want 078", r_ce_m); end
        n_cmp++; if (r_ce_p  !== 32'h0F0) begin n_bad++; $display("FAIL basic_ce_p: got %h want 0f0", r_ce_p); end
        n_cmp++; if (r_done  !== 32'h100) begin n_bad++; $display("FAIL basic_done: got %h want 100", r_done); end
        n_cmp++; if (r_busy  !== 32'h1FE) begin n_bad++; $display("FAIL basic_busy: got %h want 1fe", r_busy); end
        n_cmp++; if (r_rdy   !== 32'h03C) begin n_bad++; $display("FAIL basic_in_ready: got %h want 03c", r_rdy); end
        n_cmp++; if (r_mac   !== 32'h0FC) begin n_bad++; $display("FAIL basic_opmode_mask: got %h want 0fc", r_mac); end
        n_cmp++; if (op_c3 !== OP_MAC) begin n_bad++; $display("FAIL basic_opmode_mac: got %h want %h", op_c3, OP_MAC); end
        n_cmp++; if (op_c0 !== 8'h00) begin n_bad++; $display("FAIL basic_opmode_idle: got %h want 00", op_c0); end
    endtask

    task automatic test_stall();
        // in_valid 1,0,1,0,1 over cycles 2..6
        capture(12, 32'h1, 8'd3, 32'h54, 32'h0, 1'b0);
        n_cmp++; if (r_ce_ab !== 32'h054) begin n_bad++; $display("FAIL stall_ce_ab: got %h want 054", r_ce_ab); end
        n_cmp++; if (r_ce_m  !== 32'h0A8) begin n_bad++; $display("FAIL stall_ce_m: got %h want 0a8", r_ce_m); end
        n_cmp++; if (r_ce_p  !== 32'h150) begin n_bad++; $display("FAIL stall_ce_p: got %h want 150", r_ce_p); end
        n_cmp++; if (r_done  !== 32'h200) begin n_bad++; $display("FAIL stall_done: got %h want 200", r_done); end
        n_cmp++; if (c_done != 1) begin n_bad++; $display("FAIL stall_done_count: got %0d want 1", c_done); end
    endtask

    task automatic test_len_zero();
        capture(4, 32'h1, 8'd0, 32'hF, 32'h0, 1'b0);
        n_cmp++; if (r_rst_p !== 32'h0) begin n_bad++; $display("FAIL len0_rst_p: got %h want 0", r_rst_p); end
        n_cmp++; if ((r_ce_ab | r_ce_m | r_ce_p) !== 32'h0) begin n_bad++; $display("FAIL len0_ce: got %h want 0", r_ce_ab | r_ce_m | r_ce_p); end
        n_cmp++; if (r_done !== 32'h2) begin n_bad++; $display("FAIL len0_done: got %h want 2", r_done); end
        n_cmp++; if (r_busy !== 32'h2) begin n_bad++; $display("FAIL len0_busy: got %h want 2", r_busy); end
    endtask

    task automatic test_abort();
        // len=5, abort at cycle 4 after accepts at cycles 2,3
        capture(10, 32'h1, 8'd5, 32'hFFFF_FFFF, 32'h10, 1'b0);
        n_cmp++; if (r_ce_ab !== 32'h0C) begin n_bad++; $display("FAIL abort_ce_ab: got %h want 0c", r_ce_ab); end
        n_cmp++; if (r_rst_p !== 32'h12) begin n_bad++; $display("FAIL abort_rst_p: got %h want 12", r_rst_p); end
        n_cmp++; if (r_busy !== 32'h1E) begin n_bad++; $display("FAIL abort_busy: got %h want 1e", r_busy); end
        n_cmp++; if (((r_ce_m | r_ce_p) >> 5) !== 32'h0) begin n_bad++; $display("FAIL abort_late_ce: got %h want 0", (r_ce_m | r_ce_p) >> 5); end
        n_cmp++; if (r_ce_m[3] !== 1'b1) begin n_bad++; $display("FAIL abort_early_ce_m: got %b want 1", r_ce_m[3]); end
        n_cmp++; if (c_done != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", c_done); end
        // abort on the final accept: len=2, abort at cycle 3
        capture(8, 32'h1, 8'd2, 32'hFFFF_FFFF, 32'h08, 1'b0);
        n_cmp++; if (r_ce_ab !== 32'h4) begin n_bad++; $display("FAIL abort_last_ce_ab: got %h want 4", r_ce_ab); end
        n_cmp++; if (r_rst_p !== 32'hA) begin n_bad++; $display("FAIL abort_last_rst_p: got %h want a", r_rst_p); end
        n_cmp++; if (r_busy !== 32'hE) begin n_bad++; $display("FAIL abort_last_busy: got %h want e", r_busy); end
        n_cmp++; if (c_done != 0) begin n_bad++; $display("FAIL abort_last_done: got %0d want 0", c_done); end
    endtask

    task automatic test_reset_mid();
        // len=1: CLR c1, accept c2, DRAIN c3
        capture(3, 32'h1, 8'd1, 32'h4, 32'h0, 1'b0);
        #2;
        n_cmp++; if (busy !== 1'b1 || ce_m !== 1'b1) begin n_bad++; $display("FAIL mid_pre_state: got busy=%b ce_m=%b want 1 1", busy, ce_m); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL mid_reset_outs: got %h want 0", outs); end
        @(posedge clk);
        #2;
        n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL mid_reset_hold: got %h want 0", outs); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        capture(8, 32'h1, 8'd1, 32'hFF, 32'h0, 1'b0);
        n_cmp++; if (r_rst_p !== 32'h02) begin n_bad++; $display("FAIL post_rst_p: got %h want 02", r_rst_p); end
        n_cmp++; if (r_ce_ab !== 32'h04) begin n_bad++; $display("FAIL post_ce_ab: got %h want 04", r_ce_ab); end
        n_cmp++; if (r_ce_p  !== 32'h10) begin n_bad++; $display("FAIL post_ce_p: got %h want 10", r_ce_p); end
        n_cmp++; if (r_done  !== 32'h20) begin n_bad++; $display("FAIL post_done: got %h want 20", r_done); end
        n_cmp++; if (r_busy  !== 32'h3E) begin n_bad++; $display("FAIL post_busy: got %h want 3e", r_busy); end
    endtask

    task automatic test_back_to_back();
        // start again at cycle 3 while streaming must be ignored
        capture(14, 32'h9, 8'd4, 32'hFFFF_FFFF, 32'h0, 1'b0);
        n_cmp++; if (c_done != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", c_done); end
        n_cmp++; if (r_done !== 32'h100) begin n_bad++; $display("FAIL b2b_done: got %h want 100", r_done); end
        n_cmp++; if (r_ce_ab !== 32'h3C) begin n_bad++; $display("FAIL b2b_ce_ab: got %h want 3c", r_ce_ab); end
        n_cmp++; if (r_rst_p !== 32'h2) begin n_bad++; $display("FAIL b2b_rst_p: got %h want 2", r_rst_p); end
    endtask

    task automatic test_len_max();
        // 255 accepts on cycles 2..256, DRAIN 257..258, done at 259
        capture(264, 32'h1, 8'd255, 32'hFFFF_FFFF, 32'h0, 1'b1);
        n_cmp++; if (c_ce_ab != 255) begin n_bad++; $display("FAIL max_ce_ab_count: got %0d want 255", c_ce_ab); end
        n_cmp++; if (c_ce_p != 255) begin n_bad++; $display("FAIL max_ce_p_count: got %0d want 255", c_ce_p); end
        n_cmp++; if (c_done != 1) begin n_bad++; $display("FAIL max_done_count: got %0d want 1", c_done); end
        n_cmp++; if (done_cyc != 259) begin n_bad++; $display("FAIL max_done_cycle: got %0d want 259", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_len_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
